// File: rtl/bw_pkg.sv
// bw_pkg: shared constants, types and helpers for the Baugh-Wooley dot-product
// datapath.
//   DATA_W     operand width the multiplier is built for
//   PROD_W     multiplier product width
//   ACC_MAX_W  widest accumulator any legal LEN can need (LEN <= 256)
//   state_e    accumulator FSM states
//   sext_prod  sign-extend a product to ACC_MAX_W; callers truncate to ACC_W
package bw_pkg;

  localparam int DATA_W    = 4;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int ACC_MAX_W = PROD_W + 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Truncating the result to any ACC_W >= PROD_W still gives a correct
  // two's-complement extension, so one fixed-width helper serves every LEN.
  function automatic logic [ACC_MAX_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_MAX_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/bw_dot_accumulator_bw_multiplier.sv
// BW_MULTIPLIER: 4x4 signed two's-complement Baugh-Wooley multiplier,
// purely combinational.
//   a  in   4  signed operand
//   b  in   4  signed operand
//   c  out  8  signed product a*b
module BW_MULTIPLIER (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);

  logic [7:0] w_sum;
  logic       w_pp;

  // Partial products that pair exactly one sign bit with a magnitude bit are
  // inverted; the constant 2^4 + 2^7 corrects for those inversions mod 2^8.
  always_comb begin
    w_sum = 8'h90;
    w_pp  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pp = a[i] & b[j];
        if ((i == 3) != (j == 3)) w_pp = ~w_pp;
        if (w_pp) w_sum = w_sum + (8'd1 << (i + j));
      end
    end
  end

  assign c = w_sum;

endmodule

// File: rtl/bw_dot_accumulator.sv
// bw_dot_accumulator: accepts signed operand pairs over valid/ready, multiplies
// each pair in a Baugh-Wooley multiplier, accumulates LEN products and presents
// the dot product on a valid/ready output.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      pair can be accepted this cycle
//   a, b       in   DATA_W signed operands
//   out_valid  out  1      out_sum holds a completed dot product
//   out_ready  in   1      consumer takes out_sum
//   out_sum    out  ACC_W  signed dot product
//   out_busy   out  1      current dot product has at least one term
// Build option BW_DOT_PROD_REG_EN: registers the product ahead of the adder;
// out_valid then rises two cycles after the last accept instead of one.
//
// state | meaning
// ACCUM | taking terms, in_ready high (except while the final add completes)
// HOLD  | result presented, waiting for out_ready
module bw_dot_accumulator #(
  parameter int DATA_W = 4,
  parameter int LEN    = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_busy
);
  import bw_pkg::*;

  localparam int                CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

  if (DATA_W != bw_pkg::DATA_W) begin : g_bad_data_w
    $error("bw_dot_accumulator: DATA_W must match the multiplier width");
  end
  if (LEN < 2 || LEN > 256) begin : g_bad_len
    $error("bw_dot_accumulator: LEN must be in 2..256");
  end

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;

  logic               w_accept;
  logic [PROD_W-1:0]  w_prod;

  BW_MULTIPLIER u_mult (
    .a (a),
    .b (b),
    .c (w_prod)
  );

  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;

`ifdef BW_DOT_PROD_REG_EN

  logic [PROD_W-1:0]  r_prod;
  logic               r_p_vld;
  logic               r_last;     // final term is in r_prod, add still pending
  logic [ACC_W-1:0]   w_add;

  assign w_add    = r_p_vld ? ACC_W'(sext_prod(r_prod)) : '0;
  assign in_ready = (r_state == ACCUM) && !r_last;
  assign out_busy = (r_state == ACCUM) && ((r_cnt != '0) || r_p_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
      r_p_vld     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_p_vld <= w_accept;
          if (w_accept) r_prod <= w_prod;
          if (r_last) begin
            r_out_sum   <= r_acc + w_add;
            r_acc       <= '0;
            r_out_valid <= 1'b1;
            r_last      <= 1'b0;
            r_state     <= HOLD;
          end else begin
            r_acc <= r_acc + w_add;
          end
          if (w_accept) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt  <= '0;
              r_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

`else

  logic [ACC_W-1:0]   w_prod_ext;

  assign w_prod_ext = ACC_W'(sext_prod(w_prod));
  assign in_ready   = (r_state == ACCUM);
  assign out_busy   = (r_state == ACCUM) && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_cnt == CNT_LAST) begin
              r_out_sum   <= r_acc + w_prod_ext;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_acc <= r_acc + w_prod_ext;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

`endif

endmodule
